// File: rtl/rsa_mem_pkg.sv
// rsa_mem_pkg: op and FSM encodings plus IM geometry defaults shared with the data memory
package rsa_mem_pkg;

    localparam int ADDR_W_DEF    = 10;
    localparam int DATA_W_DEF    = 16;
    localparam int MEM_DEPTH_DEF = 1024;
    localparam int TAG_W_DEF     = 4;

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_LOAD      = 2'b01,
        OP_STORE_ALU = 2'b10,
        OP_STORE_REG = 2'b11
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } mac_state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store sequencer driving the IM data memory strobes
module mem_access_ctrl
    import rsa_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int TAG_W     = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_alu,
    input  logic [DATA_W-1:0] req_reg,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_err,
    output logic              mem_readEn,
    output logic              mem_writeEn,
    output logic              mem_mux_sel,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_ALU,
    output logic [DATA_W-1:0] mem_data_Reg,
    input  logic [DATA_W-1:0] mem_dataOut
);

    mac_state_e        r_state;
    mac_state_e        w_next;
    mem_op_e           r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_reg;
    logic [DATA_W-1:0] r_data;
    logic [TAG_W-1:0]  r_tag;
    logic              r_err;
    mem_op_e           w_op;
    logic              w_accept;
    logic              w_oor;
    logic              w_err;
    logic [DATA_W-1:0] w_src;

    assign w_op     = mem_op_e'(req_op);
    assign w_accept = req_valid && (r_state == ST_IDLE);
    // A NOP is consumed silently, so only real accesses can be flagged
    assign w_err    = w_oor && (w_op != OP_NOP);
    assign w_src    = (r_op == OP_STORE_REG) ? r_reg : r_alu;

    // With a full-size memory every address is legal and the error path stays idle
    if (MEM_DEPTH < (1 << ADDR_W)) begin : g_range
        assign w_oor = req_addr >= ADDR_W'(MEM_DEPTH);
    end else begin : g_full
        assign w_oor = 1'b0;
    end

    assign mem_address  = r_addr;
    assign mem_data_ALU = r_alu;
    assign mem_data_Reg = r_reg;
    assign mem_mux_sel  = (r_op == OP_STORE_REG);
    assign resp_data    = r_data;
    assign resp_tag     = r_tag;
    assign resp_err     = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state selection and state-decoded handshake/strobe outputs
    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        mem_readEn  = 1'b0;
        mem_writeEn = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (w_accept)
                    w_next = (w_op == OP_NOP)  ? ST_IDLE :
                             w_err             ? ST_RESP :
                             (w_op == OP_LOAD) ? ST_READ : ST_WRITE;
            end
            ST_READ: begin
                mem_readEn = 1'b1;
                w_next     = ST_WAIT;
            end
            ST_WAIT: w_next = ST_RESP;
            ST_WRITE: begin
                mem_writeEn = 1'b1;
                w_next      = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request registers: captured at acceptance and held so IM inputs stay stable between requests
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= OP_NOP;
            r_addr <= '0;
            r_alu  <= '0;
            r_reg  <= '0;
            r_tag  <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_op   <= w_op;
            r_addr <= req_addr;
            r_alu  <= req_alu;
            r_reg  <= req_reg;
            r_tag  <= req_tag;
            r_err  <= w_err;
        end
    end

    // Response word: zero for a rejected address, IM data after WAIT, the stored source after WRITE
    always_ff @(posedge clk) begin
        if (rst)                      r_data <= '0;
        else if (w_accept && w_err)   r_data <= '0;
        else if (r_state == ST_WAIT)  r_data <= mem_dataOut;
        else if (r_state == ST_WRITE) r_data <= w_src;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench with a full-size instance and a 512-word instance
module tb_mem_access_ctrl;
    import rsa_mem_pkg::*;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid    [2];
    logic          req_ready    [2];
    logic [1:0]    req_op       [2];
    logic [AW-1:0] req_addr     [2];
    logic [DW-1:0] req_alu      [2];
    logic [DW-1:0] req_reg      [2];
    logic [TW-1:0] req_tag      [2];
    logic          resp_valid   [2];
    logic          resp_ready   [2];
    logic [DW-1:0] resp_data    [2];
    logic [TW-1:0] resp_tag     [2];
    logic          resp_err     [2];
    logic          mem_readEn   [2];
    logic          mem_writeEn  [2];
    logic          mem_mux_sel  [2];
    logic [AW-1:0] mem_address  [2];
    logic [DW-1:0] mem_data_ALU [2];
    logic [DW-1:0] mem_data_Reg [2];
    logic [DW-1:0] mem_dataOut  [2];
    logic [DW-1:0] mem          [2][1024];
    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        int            inst;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          err;
        int            lat;
        int            acc;
        int            rd;
        int            wr;
        logic          mux;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // IM model: write on the writeEn edge, read data valid the cycle after readEn
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_writeEn[k]) mem[k][mem_address[k]] <= mem_mux_sel[k] ? mem_data_Reg[k] : mem_data_ALU[k];
            if (mem_readEn[k])  mem_dataOut[k] <= mem[k][mem_address[k]];
        end
    end

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(1024), .TAG_W(TW)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_addr(req_addr[0]), .req_alu(req_alu[0]), .req_reg(req_reg[0]), .req_tag(req_tag[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_data(resp_data[0]),
        .resp_tag(resp_tag[0]), .resp_err(resp_err[0]),
        .mem_readEn(mem_readEn[0]), .mem_writeEn(mem_writeEn[0]), .mem_mux_sel(mem_mux_sel[0]),
        .mem_address(mem_address[0]), .mem_data_ALU(mem_data_ALU[0]), .mem_data_Reg(mem_data_Reg[0]),
        .mem_dataOut(mem_dataOut[0])
    );

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(512), .TAG_W(TW)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_addr(req_addr[1]), .req_alu(req_alu[1]), .req_reg(req_reg[1]), .req_tag(req_tag[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_data(resp_data[1]),
        .resp_tag(resp_tag[1]), .resp_err(resp_err[1]),
        .mem_readEn(mem_readEn[1]), .mem_writeEn(mem_writeEn[1]), .mem_mux_sel(mem_mux_sel[1]),
        .mem_address(mem_address[1]), .mem_data_ALU(mem_data_ALU[1]), .mem_data_Reg(mem_data_Reg[1]),
        .mem_dataOut(mem_dataOut[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    // Issue one request; the expected response is queued with the cycle of its accepting edge
    task automatic send(input int k, input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] alu, input logic [DW-1:0] rg, input logic [TW-1:0] tag,
                        input logic [DW-1:0] ed, input logic ee, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_op[k]    = op;
        req_addr[k]  = a;
        req_alu[k]   = alu;
        req_reg[k]   = rg;
        req_tag[k]   = tag;
        for (int n = 0; n < 50 && !req_ready[k]; n++) @(negedge clk);
        if (!req_ready[k]) chk("accept_timeout", k, 32'(req_ready[k]), 1);
        if (push) begin
            e.inst = k;
            e.data = ed;
            e.tag  = tag;
            e.err  = ee;
            e.lat  = lat;
            e.acc  = cyc + 1;
            e.rd   = (op == 2'b01 && !ee) ? 1 : 0;
            e.wr   = (op[1] && !ee) ? 1 : 0;
            e.mux  = (op == 2'b11);
            q.push_back(e);
        end
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_op[k]    = 2'b00;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        chk("drain", 0, q.size(), 0);
        q.delete();
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares every presented response against the queue head and counts strobe cycles
    task automatic monitor();
        logic pv  [2];
        int   vs  [2];
        int   rdc [2];
        int   wrc [2];
        logic mx  [2];
        logic idl [2];
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            pv[k] = 1'b0; vs[k] = 0; rdc[k] = 0; wrc[k] = 0; mx[k] = 1'b0; idl[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    pv[k] = 1'b0; rdc[k] = 0; wrc[k] = 0; idl[k] = 1'b0;
                end else begin
                    if (idl[k]) begin
                        chk("idle_after_resp", k, 32'(req_ready[k]), 1);
                        chk("resp_dropped", k, 32'(resp_valid[k]), 0);
                        idl[k] = 1'b0;
                    end
                    if (mem_readEn[k]) rdc[k]++;
                    if (mem_writeEn[k]) begin
                        wrc[k]++;
                        mx[k] = mem_mux_sel[k];
                    end
                    if (resp_valid[k]) begin
                        if (!pv[k]) vs[k] = cyc;
                        chk("busy_ready", k, 32'(req_ready[k]), 0);
                        if (q.size() == 0 || q[0].inst != k) begin
                            chk("unexpected_resp", k, 32'(resp_valid[k]), 0);
                        end else begin
                            e = q[0];
                            chk("resp_data", k, 32'(resp_data[k]), 32'(e.data));
                            chk("resp_tag", k, 32'(resp_tag[k]), 32'(e.tag));
                            chk("resp_err", k, 32'(resp_err[k]), 32'(e.err));
                            if (resp_ready[k]) begin
                                chk("latency", k, vs[k] - e.acc + 1, e.lat);
                                chk("readEn_cycles", k, rdc[k], e.rd);
                                chk("writeEn_cycles", k, wrc[k], e.wr);
                                if (e.wr != 0) chk("mux_sel", k, 32'(mx[k]), 32'(e.mux));
                                void'(q.pop_front());
                                rdc[k] = 0;
                                wrc[k] = 0;
                                idl[k] = 1'b1;
                            end
                        end
                    end
                    pv[k] = resp_valid[k];
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_op[k] = 2'b00; req_addr[k] = '0; req_alu[k] = '0;
            req_reg[k] = '0; req_tag[k] = '0; resp_ready[k] = 1'b1;
        end
        fork
            monitor();
        join_none
        // Reset held two cycles with a request pending
        req_valid[0] = 1'b1;
        req_op[0]    = 2'b10;
        req_addr[0]  = 10'h005;
        req_alu[0]   = 16'hAAAA;
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", 0, 32'(req_ready[0]), 1);
            chk("rst_resp_valid", 0, 32'(resp_valid[0]), 0);
            chk("rst_readEn", 0, 32'(mem_readEn[0]), 0);
            chk("rst_writeEn", 0, 32'(mem_writeEn[0]), 0);
            chk("rst_resp_data", 0, 32'(resp_data[0]), 0);
            chk("rst_address", 0, 32'(mem_address[0]), 0);
            chk("rst_req_ready", 1, 32'(req_ready[1]), 1);
        end
        rst          = 1'b0;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("no_accept_in_rst", 0, 32'(req_ready[0]), 1);
        chk("no_write_in_rst", 0, 32'(mem_writeEn[0]), 0);

        // STORE_ALU then LOAD at 0x005
        send(0, 2'b10, 10'h005, 16'h0004, 16'h0007, 4'h1, 16'h0004, 1'b0, 2, 1'b1);
        send(0, 2'b01, 10'h005, 16'h0000, 16'h0000, 4'h3, 16'h0004, 1'b0, 3, 1'b1);
        // STORE_REG then LOAD at the top legal address
        send(0, 2'b11, 10'h3FF, 16'h0004, 16'h0007, 4'h5, 16'h0007, 1'b0, 2, 1'b1);
        send(0, 2'b01, 10'h3FF, 16'h0000, 16'h0000, 4'h6, 16'h0007, 1'b0, 3, 1'b1);
        // Address 0
        send(0, 2'b11, 10'h000, 16'h1111, 16'hBEEF, 4'h2, 16'hBEEF, 1'b0, 2, 1'b1);
        send(0, 2'b01, 10'h000, 16'h0000, 16'h0000, 4'hF, 16'hBEEF, 1'b0, 3, 1'b1);
        // NOP is consumed without a response
        send(0, 2'b00, 10'h009, 16'h5A5A, 16'hA5A5, 4'hC, 16'h0000, 1'b0, 0, 1'b0);
        wait_idle();
        chk("nop_ready", 0, 32'(req_ready[0]), 1);

        // Backpressure: LOAD held in RESP for five cycles
        resp_ready[0] = 1'b0;
        send(0, 2'b01, 10'h005, 16'h0000, 16'h0000, 4'h7, 16'h0004, 1'b0, 3, 1'b1);
        for (int n = 0; n < 20 && !resp_valid[0]; n++) @(negedge clk);
        repeat (5) begin
            chk("bp_valid", 0, 32'(resp_valid[0]), 1);
            chk("bp_req_ready", 0, 32'(req_ready[0]), 0);
            @(negedge clk);
        end
        resp_ready[0] = 1'b1;
        wait_idle();

        // Reset during WAIT of a LOAD: response dropped, then a clean reload
        send(0, 2'b01, 10'h005, 16'h0000, 16'h0000, 4'h9, 16'h0000, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ready", 0, 32'(req_ready[0]), 1);
        chk("midrst_readEn", 0, 32'(mem_readEn[0]), 0);
        chk("midrst_resp_valid", 0, 32'(resp_valid[0]), 0);
        repeat (4) @(negedge clk);
        send(0, 2'b01, 10'h005, 16'h0000, 16'h0000, 4'h8, 16'h0004, 1'b0, 3, 1'b1);
        wait_idle();

        // 512-word instance: range boundary and error path
        send(1, 2'b01, 10'h200, 16'h0000, 16'h0000, 4'h4, 16'h0000, 1'b1, 1, 1'b1);
        send(1, 2'b10, 10'h1FF, 16'h1234, 16'h4321, 4'h1, 16'h1234, 1'b0, 2, 1'b1);
        send(1, 2'b01, 10'h1FF, 16'h0000, 16'h0000, 4'h2, 16'h1234, 1'b0, 3, 1'b1);
        send(1, 2'b01, 10'h3FF, 16'h0000, 16'h0000, 4'hA, 16'h0000, 1'b1, 1, 1'b1);
        send(1, 2'b11, 10'h200, 16'h5555, 16'h6666, 4'hB, 16'h0000, 1'b1, 1, 1'b1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
